// File: rtl/min_scan_ctrl.sv
// Minimum-metric scan controller: reads 64 path metrics as 8 groups of 8 and
// tracks the smallest one (lowest state number on ties) for renormalisation.
module min_scan_ctrl #(
    parameter int M = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    output logic             rd_en,
    output logic [2:0]       grp_addr,
    input  logic [8*(M+1)-1:0] grp_data,
    input  logic [2:0]       sel_idx,
    output logic             busy,
    output logic             done,
    output logic [5:0]       best_state,
    output logic [M:0]       best_metric
);
    localparam int W = M + 1;

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    state_t     state_q, state_d;
    logic [2:0] cnt_q;
    logic       dv_q;
    logic [2:0] dg_q;
    logic [M:0] min_q;
    logic [5:0] min_st_q;

    logic [M:0] cand_metric;
    logic [5:0] cand_state;
    logic       take;
    logic [M:0] nxt_min;
    logic [5:0] nxt_st;

    // Group 0 seeds the running minimum; later groups need a strict win.
    always_comb begin
        cand_metric = grp_data[sel_idx*W +: W];
        cand_state  = {dg_q, sel_idx};
        take        = dv_q && ((dg_q == 3'd0) || (cand_metric < min_q));
        nxt_min     = take ? cand_metric : min_q;
        nxt_st      = take ? cand_state  : min_st_q;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: state_d = (start && !abort) ? READ : IDLE;
            READ:       state_d = abort ? IDLE : ((cnt_q == 3'd7) ? DRAIN : READ);
            DRAIN:      state_d = abort ? IDLE : DONE;
            default:    state_d = IDLE;
        endcase
    end

    assign rd_en    = (state_q == READ);
    assign grp_addr = rd_en ? cnt_q : 3'd0;
    assign busy     = (state_q == READ) || (state_q == DRAIN);
    assign done     = (state_q == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= 3'd0;
            dv_q        <= 1'b0;
            dg_q        <= 3'd0;
            min_q       <= '0;
            min_st_q    <= 6'd0;
            best_state  <= 6'd0;
            best_metric <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= (rd_en && !abort) ? cnt_q + 3'd1 : 3'd0;
            dv_q    <= rd_en && !abort;
            dg_q    <= cnt_q;
            if (dv_q) begin
                min_q    <= nxt_min;
                min_st_q <= nxt_st;
            end
            // DRAIN carries the last group's data, so fold it in directly.
            if (state_q == DRAIN && !abort) begin
                best_state  <= nxt_st;
                best_metric <= nxt_min;
            end
        end
    end
endmodule

// File: tb/tb_min_scan_ctrl.sv
// Bench for min_scan_ctrl: RAM and min-finder models, scan timing checks and a
// scoreboard comparing each done result against a linear reference scan.
module tb_min_scan_ctrl;
    localparam int M = 6;
    localparam int W = M + 1;

    logic           clk;
    logic           rst_n;
    logic           start;
    logic           abort;
    logic           rd_en;
    logic [2:0]     grp_addr;
    logic [8*W-1:0] grp_data;
    logic [2:0]     sel_idx;
    logic           busy;
    logic           done;
    logic [5:0]     best_state;
    logic [M:0]     best_metric;

    logic [M:0]     mem [64];
    logic [12:0]    exp_q [$];
    int             n_checks;
    int             n_errors;

    min_scan_ctrl #(.M(M)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .rd_en(rd_en), .grp_addr(grp_addr), .grp_data(grp_data),
        .sel_idx(sel_idx), .busy(busy), .done(done),
        .best_state(best_state), .best_metric(best_metric)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // metric RAM: one-cycle read latency
    always @(posedge clk) begin
        if (rd_en)
            for (int j = 0; j < 8; j++)
                grp_data[j*W +: W] <= mem[{grp_addr, 3'(j)}];
    end

    // external 8-way minimum finder, lowest index on ties
    always_comb begin
        logic [M:0] m;
        sel_idx = 3'd0;
        m = grp_data[0 +: W];
        for (int j = 1; j < 8; j++)
            if (grp_data[j*W +: W] < m) begin
                m = grp_data[j*W +: W];
                sel_idx = 3'(j);
            end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [12:0] ref_min();
        logic [5:0] s;
        logic [M:0] m;
        s = 6'd0;
        m = mem[0];
        for (int i = 1; i < 64; i++)
            if (mem[i] < m) begin
                m = mem[i];
                s = 6'(i);
            end
        return {s, m};
    endfunction

    // scoreboard: every done pulse must match the oldest expected result
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                logic [12:0] e;
                e = exp_q.pop_front();
                check("best_state", 32'(best_state), 32'(e[12:7]));
                check("best_metric", 32'(best_metric), 32'(e[6:0]));
            end
        end
    end

    task automatic fill(input logic [M:0] v);
        for (int i = 0; i < 64; i++) mem[i] = v;
    endtask

    // one start pulse, then cycle-by-cycle protocol checks through cycle 10
    task automatic run_scan();
        exp_q.push_back(ref_min());
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int cyc = 1; cyc <= 10; cyc++) begin
            if (cyc > 1) @(negedge clk);
            check("rd_en", 32'(rd_en), 32'(cyc <= 8));
            check("grp_addr", 32'(grp_addr), (cyc <= 8) ? 32'(cyc - 1) : 32'd0);
            check("busy", 32'(busy), 32'(cyc <= 9));
            check("done", 32'(done), 32'(cyc == 10));
        end
        @(negedge clk);
        check("done_single", 32'(done), 32'd0);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        start = 1'b0;
        abort = 1'b0;
        grp_data = '0;
        fill(7'd20);
        rst_n = 1'b0;
        #1;
        check("rst_rd_en", 32'(rd_en), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_best_state", 32'(best_state), 32'd0);
        check("rst_best_metric", 32'(best_metric), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // single minimum at state 45
        mem[45] = 7'd3;
        run_scan();

        // all equal -> state 0
        fill(7'd12);
        run_scan();

        // tie between states 9 and 50
        fill(7'd30);
        mem[9] = 7'd1;
        mem[50] = 7'd1;
        run_scan();

        // random metrics in a narrow range to force ties
        for (int t = 0; t < 3; t++) begin
            for (int i = 0; i < 64; i++) mem[i] = 7'($urandom_range(2, 15));
            run_scan();
        end

        // start held high: back-to-back scans every 10 cycles
        fill(7'd127);
        mem[63] = 7'd0;
        for (int k = 0; k < 3; k++) exp_q.push_back(ref_min());
        @(negedge clk); start = 1'b1;
        for (int cyc = 1; cyc <= 30; cyc++) begin
            @(negedge clk);
            if (cyc == 30) start = 1'b0;
            check("cont_done", 32'(done), 32'(cyc % 10 == 0));
            check("cont_busy", 32'(busy), 32'(cyc % 10 != 0));
        end
        @(negedge clk);
        check("cont_idle", 32'(busy), 32'd0);

        // establish best_state=45, then abort at cycle 5
        fill(7'd20);
        mem[45] = 7'd3;
        run_scan();
        fill(7'd40);
        mem[2] = 7'd0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (4) @(negedge clk);
        abort = 1'b1;
        check("abort_busy_before", 32'(busy), 32'd1);
        @(negedge clk); abort = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_rd_en", 32'(rd_en), 32'd0);
        check("abort_addr", 32'(grp_addr), 32'd0);
        repeat (10) @(negedge clk);
        check("abort_keep_state", 32'(best_state), 32'd45);
        check("abort_keep_metric", 32'(best_metric), 32'd3);

        // abort together with start in IDLE: no scan
        start = 1'b1; abort = 1'b1;
        @(negedge clk); start = 1'b0; abort = 1'b0;
        check("abort_start_busy", 32'(busy), 32'd0);
        run_scan();

        // asynchronous reset mid-scan at cycle 4
        fill(7'd50);
        mem[17] = 7'd5;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_rst_busy", 32'(busy), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("arst_rd_en", 32'(rd_en), 32'd0);
        check("arst_addr", 32'(grp_addr), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        check("arst_best_state", 32'(best_state), 32'd0);
        check("arst_best_metric", 32'(best_metric), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check("post_rst_busy", 32'(busy), 32'd0);
        run_scan();

        repeat (3) @(negedge clk);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
